// File: rtl/quad_encoder_sampler_if.sv
// quad_encoder_sampler_if: encoder pins, controls and sampled results of the quadrature front end
interface quad_encoder_sampler_if #(
  parameter int WIDTH     = 16,
  parameter int POS_WIDTH = 32,
  parameter int ERR_WIDTH = 8
);
  logic                        enc_a;
  logic                        enc_b;
  logic                        en;
  logic                        clr_err;
  logic signed [WIDTH-1:0]     sample_out;
  logic                        sample_valid;
  logic signed [POS_WIDTH-1:0] position;
  logic                        err_strobe;
  logic [ERR_WIDTH-1:0]        err_count;
  modport master (
    output enc_a, enc_b, en, clr_err,
    input  sample_out, sample_valid, position, err_strobe, err_count
  );
  modport slave (
    input  enc_a, enc_b, en, clr_err,
    output sample_out, sample_valid, position, err_strobe, err_count
  );
endinterface

// File: rtl/quad_encoder_sampler.sv
// quad_encoder_sampler: quadrature decode to position, windowed saturating tick delta, illegal-transition counting
module quad_encoder_sampler #(
  parameter int WIDTH         = 16,
  parameter int POS_WIDTH     = 32,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_WIDTH     = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  quad_encoder_sampler_if.slave  bus
);
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SYNC_STAGES);
  localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [SYNC_STAGES-1:0] sa_q, sb_q;
  logic [1:0]             prev_q, cur, mv, step;
  logic                   primed_q, fwd, rev, ill, last;
  logic [PW-1:0]          pcnt_q;
  logic [TW-1:0]          timer_q;
  logic [WIDTH-1:0]       delta_q, sample_q, sat_d;
  logic [WIDTH:0]         sum;
  logic [POS_WIDTH-1:0]   pos_q, pos_d;
  logic [ERR_WIDTH-1:0]   errc_q, errc_d;
  logic                   valid_q, err_q;
  // Gray codes map to a binary phase, so the phase difference mod 4 classifies the move
  always_comb begin
    cur   = {sa_q[SYNC_STAGES-1], sb_q[SYNC_STAGES-1]};
    mv    = {cur[1], ^cur} - {prev_q[1], ^prev_q};
    fwd   = primed_q && mv == 2'd1;
    rev   = primed_q && mv == 2'd3;
    ill   = primed_q && mv == 2'd2;
    step  = fwd ? 2'b01 : rev ? 2'b11 : 2'b00;
    sum   = {delta_q[WIDTH-1], delta_q} + {{(WIDTH-1){step[1]}}, step};
    sat_d = sum[WIDTH] != sum[WIDTH-1] ? (sum[WIDTH] ? S_MIN : S_MAX) : sum[WIDTH-1:0];
    pos_d = pos_q + {{(POS_WIDTH-2){step[1]}}, step};
    errc_d = bus.clr_err ? ERR_WIDTH'(ill) : errc_q + ERR_WIDTH'(ill && !(&errc_q));
    last  = timer_q == T_LAST;
  end
  // Synchronize, prime, decode and run the sample window; prev_q tracks cur every cycle so priming needs no special load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_q     <= '0;
      sb_q     <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
      pcnt_q   <= '0;
      timer_q  <= '0;
      delta_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      pos_q    <= '0;
      err_q    <= 1'b0;
      errc_q   <= '0;
    end else begin
      sa_q     <= {sa_q[SYNC_STAGES-2:0], bus.enc_a};
      sb_q     <= {sb_q[SYNC_STAGES-2:0], bus.enc_b};
      prev_q   <= cur;
      primed_q <= primed_q || pcnt_q == P_LAST;
      pcnt_q   <= primed_q || pcnt_q == P_LAST ? pcnt_q : pcnt_q + 1'b1;
      timer_q  <= bus.en && !last ? timer_q + 1'b1 : '0;
      delta_q  <= bus.en && !last ? sat_d : '0;
      sample_q <= bus.en && last ? sat_d : sample_q;
      valid_q  <= bus.en && last;
      pos_q    <= pos_d;
      err_q    <= ill;
      errc_q   <= errc_d;
    end
  end
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.position     = pos_q;
  assign bus.err_strobe   = err_q;
  assign bus.err_count    = errc_q;
endmodule

// File: doc/quad_encoder_sampler.md
Name: quad_encoder_sampler

Overview:
- Quadrature encoder front end. It decodes the A/B channels into a signed position count and emits a signed per-window tick delta with a one-cycle valid strobe.
- The strobe drives the low-pass filter `en` and the delta drives its `in`, so the filter receives one velocity sample per window.
- It also detects illegal Gray-code transitions and keeps a saturating error count for the host.

Parameters:
- WIDTH, 16: width of the signed sample output; matches the filter input width.
- POS_WIDTH, 32: width of the signed wrapping position counter.
- SAMPLE_PERIOD, 1000: clk cycles per sample window; must be ≥2.
- SYNC_STAGES, 2: synchronizer flops per encoder input; must be ≥2.
- ERR_WIDTH, 8: width of the saturating error counter.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- enc_a, input, 1: encoder channel A, asynchronous.
- enc_b, input, 1: encoder channel B, asynchronous.
- en, input, 1: enables windowed sampling.
- clr_err, input, 1: synchronous clear of err_count.
- sample_out, output, WIDTH signed: tick delta of the last completed window.
- sample_valid, output, 1: one-cycle strobe when sample_out updates.
- position, output, POS_WIDTH signed: accumulated position.
- err_strobe, output, 1: one-cycle pulse per illegal transition.
- err_count, output, ERR_WIDTH: saturating count of illegal transitions.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Synchronizers, prev_state, delta, timer, position, sample_out, err_count: 0.
  - sample_valid, err_strobe: 0.
  - primed: 0.
  - Reset asserted mid-window discards the partial window; no strobe is issued.
- Synchronization:
  - enc_a and enc_b each pass through SYNC_STAGES flops; the synchronized pair is cur = {A,B}.
- Priming:
  - For the first SYNC_STAGES cycles after reset release, no decode occurs.
  - On the next cycle, prev_state <= cur and primed <= 1, with no step and no error.
  - This prevents a spurious step when the encoder rests at a non-00 state.
- Decode (when primed, every cycle):
  - Forward sequence 00→01→11→10→00 gives step = +1.
  - The reverse of that sequence gives step = -1.
  - cur == prev_state gives step = 0.
  - A two-bit change (00↔11, 01↔10) is illegal: step = 0, err_strobe = 1 for that cycle, err_count += 1, saturating at 2^ERR_WIDTH-1.
  - prev_state <= cur in all cases.
  - Decode latency from pin to position update is SYNC_STAGES+1 cycles.
- Position:
  - position += step every cycle, independent of en.
  - Two's-complement wrap at the POS_WIDTH limits.
- Error clear:
  - clr_err forces err_count to 0.
  - If an illegal transition occurs in the same cycle as clr_err, err_count becomes 1 (increment applied after the clear).
- Windowing (en = 1):
  - timer counts 0..SAMPLE_PERIOD-1, then wraps to 0.
  - On non-terminal cycles, delta <= sat(delta + step).
  - On the terminal cycle (timer == SAMPLE_PERIOD-1):
    - sample_out <= sat(delta + step); the step landing in this cycle belongs to the closing window.
    - delta <= 0 and sample_valid <= 1 for exactly one cycle.
  - Strobes are spaced exactly SAMPLE_PERIOD cycles apart.
  - The first strobe after en rises comes SAMPLE_PERIOD cycles after the first enabled cycle.
- Windowing (en = 0):
  - timer and delta are held at 0; no strobe is issued.
  - sample_out holds its last value.
  - A window interrupted by en falling is discarded.
- Saturation:
  - The delta accumulator is signed WIDTH and clamps at +2^(WIDTH-1)-1 and -2^(WIDTH-1); it does not wrap.
- Registered outputs:
  - All outputs are registered; there are no combinational paths from the encoder pins.

Test Plan (SAMPLE_PERIOD=100, SYNC_STAGES=2 unless noted):
- Reset check: reset_n low with enc_a = enc_b = 1 -> all outputs 0; after release and the priming cycles, position is still 0 and err_count is 0.
- Forward count: en = 1, 10 forward Gray steps spaced 5 cycles inside one window -> sample_out = +10, position = 10; sample_valid is high for one cycle at window ends 100 cycles apart; the next idle window gives sample_out = 0.
- Reverse count: after the forward test, 6 reverse steps in one window -> sample_out = -6, position = 4.
- Illegal transition: jump from 00 to 11 -> err_strobe high for one cycle, err_count = 1, position and delta unchanged. Then clr_err pulsed together with a 01→10 jump -> err_count = 1.
- Boundary step: one forward step whose decode lands on the terminal timer cycle -> included in that window's sample (+1); the following window gives 0.
- Saturation and enable: WIDTH=4, 12 forward steps in one window -> sample_out = +7. Drop en mid-window after 3 steps, then raise it again -> no strobe while en is low, the discarded steps are absent from the next sample, and position still includes them. With ERR_WIDTH=8 and 300 illegal jumps -> err_count = 255.
